// File: rtl/sdram_write.sv
// Write-burst engine: ACTIVE/WRITE/BST/PRECHARGE for one full-page burst, FIFO drained via wr_ack; wr_end after TRCD+L+TWR+TRP cycles, no backpressure once granted.
// Optional `SDRAM_WR_PAGE_GUARD_EN truncates the burst at the row end instead of wrapping the column.
module sdram_write #(
   parameter int TRCD_CLK = 2,
   parameter int TWR_CLK  = 2,
   parameter int TRP_CLK  = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        init_end,
   input  logic        wr_en,
   input  logic [23:0] wr_addr,
   input  logic [15:0] wr_data,
   input  logic [9:0]  wr_burst_len,
   output logic        wr_ack,
   output logic        wr_end,
   output logic [3:0]  wr_sdram_cmd,
   output logic [1:0]  wr_sdram_ba,
   output logic [12:0] wr_sdram_addr,
   output logic        wr_sdram_en,
   output logic [15:0] wr_sdram_data
);

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_ACT = 4'b0011;
   localparam logic [3:0] CMD_WR  = 4'b0100;
   localparam logic [3:0] CMD_BST = 4'b0110;
   localparam logic [3:0] CMD_PRE = 4'b0010;

   localparam int WAIT_MAX = (TRCD_CLK > TWR_CLK) ? ((TRCD_CLK > TRP_CLK) ? TRCD_CLK : TRP_CLK)
                                                  : ((TWR_CLK > TRP_CLK) ? TWR_CLK : TRP_CLK);
   localparam int WW = $clog2(WAIT_MAX + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_ACTIVE, S_TRCD, S_WRITE, S_DATA, S_BST, S_TWR, S_PRE, S_TRP, S_END
   } state_t;

   state_t        state_q;
   logic [3:0]    cmd_q;
   logic [1:0]    ba_q;
   logic [12:0]   addr_q;
   logic          ack_q, end_q, en_q;
   logic [WW-1:0] wait_q;
   logic [9:0]    cnt_q, len_q, len_d;
   logic [8:0]    col_q;

   // Effective burst length: clamp to one page, optionally stop at the row end.
`ifdef SDRAM_WR_PAGE_GUARD_EN
   logic [9:0] room;
   always_comb begin
      len_d = (wr_burst_len > 10'd512) ? 10'd512 : wr_burst_len;
      room  = 10'd512 - {1'b0, wr_addr[8:0]};
      if (len_d > room) len_d = room;
   end
`else
   always_comb begin
      len_d = (wr_burst_len > 10'd512) ? 10'd512 : wr_burst_len;
   end
`endif

   // Outputs are registered for the cycle being entered; wr_ack leads wr_sdram_en by one cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cmd_q   <= CMD_NOP;
         ba_q    <= 2'b00;
         addr_q  <= 13'h1FFF;
         ack_q   <= 1'b0;
         end_q   <= 1'b0;
         en_q    <= 1'b0;
         wait_q  <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         col_q   <= '0;
      end else begin
         cmd_q  <= CMD_NOP;
         addr_q <= 13'h1FFF;
         end_q  <= 1'b0;
         case (state_q)
            S_IDLE: if (wr_en && init_end) begin
               len_q <= len_d;
               col_q <= wr_addr[8:0];
               if (len_d == 10'd0) begin
                  state_q <= S_END;
                  end_q   <= 1'b1;
               end else begin
                  state_q <= S_ACTIVE;
                  cmd_q   <= CMD_ACT;
                  ba_q    <= wr_addr[23:22];
                  addr_q  <= wr_addr[21:9];
                  wait_q  <= WW'(TRCD_CLK - 1);
                  ack_q   <= (TRCD_CLK == 1);
               end
            end
            S_ACTIVE, S_TRCD: begin
               if (wait_q == '0) begin
                  state_q <= S_WRITE;
                  cmd_q   <= CMD_WR;
                  addr_q  <= {4'b0000, col_q};
                  en_q    <= 1'b1;
                  cnt_q   <= 10'd1;
                  ack_q   <= (len_q > 10'd1);
               end else begin
                  state_q <= S_TRCD;
                  wait_q  <= wait_q - WW'(1);
                  ack_q   <= (wait_q == WW'(1));
               end
            end
            S_WRITE, S_DATA: begin
               if (cnt_q == len_q) begin
                  state_q <= S_BST;
                  cmd_q   <= CMD_BST;
                  en_q    <= 1'b0;
                  ack_q   <= 1'b0;
               end else begin
                  state_q <= S_DATA;
                  cnt_q   <= cnt_q + 10'd1;
                  ack_q   <= ((cnt_q + 10'd1) < len_q);
               end
            end
            S_BST: begin
               if (TWR_CLK <= 2) begin
                  state_q <= S_PRE;
                  cmd_q   <= CMD_PRE;
                  addr_q  <= 13'h0000;
               end else begin
                  state_q <= S_TWR;
                  wait_q  <= WW'(TWR_CLK - 3);
               end
            end
            S_TWR: begin
               if (wait_q == '0) begin
                  state_q <= S_PRE;
                  cmd_q   <= CMD_PRE;
                  addr_q  <= 13'h0000;
               end else begin
                  wait_q  <= wait_q - WW'(1);
               end
            end
            S_PRE: begin
               if (TRP_CLK <= 1) begin
                  state_q <= S_END;
                  end_q   <= 1'b1;
               end else begin
                  state_q <= S_TRP;
                  wait_q  <= WW'(TRP_CLK - 2);
               end
            end
            S_TRP: begin
               if (wait_q == '0) begin
                  state_q <= S_END;
                  end_q   <= 1'b1;
               end else begin
                  wait_q  <= wait_q - WW'(1);
               end
            end
            S_END:   state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign wr_ack        = ack_q;
   assign wr_end        = end_q;
   assign wr_sdram_cmd  = cmd_q;
   assign wr_sdram_ba   = ba_q;
   assign wr_sdram_addr = addr_q;
   assign wr_sdram_en   = en_q;
   assign wr_sdram_data = en_q ? wr_data : 16'h0000;

endmodule

// File: tb/tb_sdram_write.sv
// Bench for sdram_write: randomized and directed bursts checked by an event scoreboard.
module tb_sdram_write;

   localparam int TRCD = 2;
   localparam int TWR  = 2;
   localparam int TRP  = 2;

   logic        clk, rstn, init_end, wr_en;
   logic [23:0] wr_addr;
   logic [15:0] wr_data;
   logic [9:0]  wr_burst_len;
   logic        wr_ack, wr_end, wr_sdram_en;
   logic [3:0]  wr_sdram_cmd;
   logic [1:0]  wr_sdram_ba;
   logic [12:0] wr_sdram_addr;
   logic [15:0] wr_sdram_data;

   sdram_write #(.TRCD_CLK(TRCD), .TWR_CLK(TWR), .TRP_CLK(TRP)) dut (
      .clk(clk), .rstn(rstn), .init_end(init_end), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_burst_len(wr_burst_len),
      .wr_ack(wr_ack), .wr_end(wr_end), .wr_sdram_cmd(wr_sdram_cmd),
      .wr_sdram_ba(wr_sdram_ba), .wr_sdram_addr(wr_sdram_addr),
      .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   typedef struct { int c; logic [3:0] cmd; logic [1:0] ba; logic [12:0] addr; } cev_t;
   typedef struct { int c; logic [15:0] d; } dev_t;

   cev_t        cmd_eq[$];
   dev_t        dat_eq[$];
   int          ack_eq[$];
   int          end_eq[$];
   logic [15:0] fifo[$];
   int          next_free = 0;
   bit          ack_seen = 1'b0;

   // Reference: event cycles straight from the burst timing rules.
   task automatic model(input int c0, input logic [23:0] a, input int len, output int c_end);
      int L, col;
      logic [1:0] bk;
      logic [15:0] w;
      col = int'(a[8:0]);
      bk  = a[23:22];
      L   = (len > 512) ? 512 : len;
`ifdef SDRAM_WR_PAGE_GUARD_EN
      if (L > 512 - col) L = 512 - col;
`endif
      if (L == 0) begin
         c_end = c0 + 1;
      end else begin
         cmd_eq.push_back('{c0 + 1,               4'b0011, bk, a[21:9]});
         cmd_eq.push_back('{c0 + 1 + TRCD,        4'b0100, bk, {4'b0000, a[8:0]}});
         cmd_eq.push_back('{c0 + 1 + TRCD + L,    4'b0110, bk, 13'h1FFF});
         cmd_eq.push_back('{c0 + TRCD + L + TWR,  4'b0010, bk, 13'h0000});
         for (int i = 0; i < L; i++) begin
            w = 16'($urandom);
            ack_eq.push_back(c0 + TRCD + i);
            fifo.push_back(w);
            dat_eq.push_back('{c0 + 1 + TRCD + i, w});
         end
         c_end = c0 + TRCD + L + TWR + TRP;
      end
      end_eq.push_back(c_end);
   endtask

   task automatic burst(input logic [23:0] a, input int len, input bit hold);
      int e;
      while (cyc < next_free) begin
         @(posedge clk); #1;
      end
      wr_addr      = a;
      wr_burst_len = len[9:0];
      wr_en        = 1'b1;
      model(cyc, a, len, e);
      next_free = e + 1;
      @(posedge clk); #1;
      if (!hold) wr_en = 1'b0;
   endtask

   // Write FIFO: word appears the cycle after wr_ack.
   always @(posedge clk) begin
      bit a;
      a = ack_seen;
      #1;
      if (a && fifo.size() > 0) wr_data = fifo.pop_front();
      else                      wr_data = 16'($urandom);
   end

   // Monitor / scoreboard.
   always @(negedge clk) begin
      cev_t ce;
      dev_t de;
      int   ex;
      if (!rstn) begin
         ack_seen = 1'b0;
      end else begin
         ack_seen = wr_ack;
         if (wr_sdram_cmd != 4'b0111) begin
            if (cmd_eq.size() == 0) chk("unexpected_cmd", wr_sdram_cmd, 4'b0111);
            else begin
               ce = cmd_eq.pop_front();
               chk("cmd_cycle", cyc, ce.c);
               chk("cmd", wr_sdram_cmd, ce.cmd);
               chk("cmd_ba", wr_sdram_ba, ce.ba);
               chk("cmd_addr", wr_sdram_addr, ce.addr);
            end
         end else begin
            chk("nop_addr", wr_sdram_addr, 13'h1FFF);
         end
         if (wr_ack) begin
            if (ack_eq.size() == 0) chk("unexpected_ack", wr_ack, 1'b0);
            else begin
               ex = ack_eq.pop_front();
               chk("ack_cycle", cyc, ex);
            end
         end
         if (wr_sdram_en) begin
            if (dat_eq.size() == 0) chk("unexpected_en", wr_sdram_en, 1'b0);
            else begin
               de = dat_eq.pop_front();
               chk("data_cycle", cyc, de.c);
               chk("data", wr_sdram_data, de.d);
            end
         end else begin
            chk("idle_data", wr_sdram_data, 16'h0000);
         end
         if (wr_end) begin
            if (end_eq.size() == 0) chk("unexpected_end", wr_end, 1'b0);
            else begin
               ex = end_eq.pop_front();
               chk("end_cycle", cyc, ex);
            end
         end
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd"},  wr_sdram_cmd,  4'b0111);
      chk({tag, "_addr"}, wr_sdram_addr, 13'h1FFF);
      chk({tag, "_ba"},   wr_sdram_ba,   2'b00);
      chk({tag, "_ack"},  wr_ack,        1'b0);
      chk({tag, "_end"},  wr_end,        1'b0);
      chk({tag, "_en"},   wr_sdram_en,   1'b0);
      chk({tag, "_data"}, wr_sdram_data, 16'h0000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int start, len, col;
      logic [23:0] a;
      rstn = 1'b0; init_end = 1'b0; wr_en = 1'b0;
      wr_addr = '0; wr_burst_len = '0; wr_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      #2 rstn = 1'b1;

      // Grant without init_end must be ignored.
      wr_en = 1'b1;
      wr_addr = 24'h4_0A05; wr_burst_len = 10'd4;
      repeat (6) @(posedge clk);
      #1;
      chk("no_init_cmd", wr_sdram_cmd, 4'b0111);
      chk("no_init_ack", wr_ack, 1'b0);
      wr_en = 1'b0;
      init_end = 1'b1;
      next_free = cyc + 1;

      burst(24'h4_0A05, 4, 1'b0);
      burst(24'h1_2345, 0, 1'b0);
      burst({2'b10, 13'h0123, 9'd508}, 8, 1'b0);
      burst(24'hC0_0010, 600, 1'b1);
      burst(24'h3F_FFF0, 3, 1'b0);

      // Reset in the middle of the data phase.
      while (cyc < next_free) begin
         @(posedge clk); #1;
      end
      start = cyc;
      burst(24'h4_0A05, 6, 1'b0);
      while (cyc < start + TRCD + 3) begin
         @(posedge clk); #1;
      end
      #2 rstn = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      cmd_eq.delete(); dat_eq.delete(); ack_eq.delete(); end_eq.delete(); fifo.delete();
      repeat (2) @(posedge clk);
      #3 rstn = 1'b1;
      next_free = cyc + 1;
      burst(24'h4_0A05, 4, 1'b0);

      for (int i = 0; i < 12; i++) begin
         case ($urandom_range(0, 5))
            0:       len = 0;
            1:       len = $urandom_range(1, 2);
            default: len = $urandom_range(1, 24);
         endcase
         col = ($urandom_range(0, 2) == 0) ? $urandom_range(495, 511) : $urandom_range(0, 511);
         a = {2'($urandom), 13'($urandom), 9'(col)};
         burst(a, len, (i < 11) ? 1'($urandom) : 1'b0);
      end

      while (cyc < next_free + 5) begin
         @(posedge clk); #1;
      end
      chk("pending_cmd", cmd_eq.size(), 0);
      chk("pending_ack", ack_eq.size(), 0);
      chk("pending_data", dat_eq.size(), 0);
      chk("pending_end", end_eq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
